// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared state encoding and bubble value for pipeline stage buffers
package pipe_stage_buf_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_e;
  localparam logic [1023:0] BUBBLE = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter, holds at all-ones
// Ports: clk, reset (async active-low), inc (count this cycle), count (current value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with optional skid entry, stall/flush and debug counters
// Ports: clk, reset (async active-low); in_valid/in_ready/in_data upstream handshake;
// out_valid/out_ready/out_data downstream handshake; stall holds, flush empties the stage;
// occupancy = entries held; stall_cnt/flush_cnt = saturating hazard cycle counters.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic             push, pop, hold;
  always_comb begin
    hold      = stall | flush;
    // with a skid entry in_ready is decoupled from out_ready; without one it passes through
    in_ready  = reset & ~hold & ((SKID != 0) ? (state_q != TWO) : (state_q == EMPTY || out_ready));
    out_valid = (state_q != EMPTY) & ~hold;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    state_d   = flush               ? EMPTY :
                (state_q == EMPTY)  ? (push ? ONE : EMPTY) :
                (state_q == ONE)    ? ((push & ~pop) ? TWO : (pop & ~push) ? EMPTY : ONE) :
                                      (pop ? ONE : TWO);
    head_d    = flush                        ? '0 :
                (push & (state_q == EMPTY | pop)) ? in_data :
                (pop & (state_q == TWO))     ? skid_q : head_q;
    skid_d    = flush                                 ? '0 :
                (push & ~pop & (state_q == ONE))      ? in_data : skid_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  assign out_data  = (state_q != EMPTY) ? head_q : BUBBLE[WIDTH-1:0];
  assign occupancy = state_q;
  // a cycle with both stall and flush is attributed to flush only
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall & ~flush), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(flush),          .count(flush_cnt));
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register for the RV pipeline, replacing the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latch structs.
- Carries an opaque WIDTH-bit payload, normally one packed stage struct.
- Uses a valid/ready handshake and an optional skid entry so in_ready does not depend combinationally on out_ready.
- Provides stall (hold), flush (bubble insertion) and saturating stall/flush counters for hazard debugging.

Parameters:
WIDTH, 32, payload bits (set to $bits of the stage struct).
SKID, 1, 1 = two-entry skid buffer; 0 = single entry with ready pass-through.
CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream accepts.
out_data  out  WIDTH  head payload.
stall  in  1  hold the stage: no accept, no emit.
flush  in  1  discard all entries (bubble insertion).
occupancy  out  2  entries held, 0..2.
stall_cnt  out  CNT_W  cycles with stall=1 and flush=0, saturating.
flush_cnt  out  CNT_W  cycles with flush=1, saturating.

Behaviour:
- Reset (reset=0, async): state EMPTY; head, skid, out_data, stall_cnt and flush_cnt = 0; out_valid=0; in_ready=0 while reset is asserted.
- States: EMPTY, ONE, TWO. TWO exists only when SKID=1.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (state != EMPTY) & ~stall & ~flush.
- out_data = head when state != EMPTY, else 0 (bubble).
- in_ready:
  - SKID=1: (state != TWO) & ~stall & ~flush. Never depends on out_ready.
  - SKID=0: ~stall & ~flush & (state == EMPTY | out_ready).
- Transitions:
  - EMPTY: push -> ONE, head <= in_data.
  - ONE, push & ~pop -> TWO, skid <= in_data (SKID=1 only).
  - ONE, pop & ~push -> EMPTY.
  - ONE, push & pop -> ONE, head <= in_data.
  - TWO, pop -> ONE, head <= skid. in_ready=0 in TWO, so there is no push.
- Priority order: flush > stall > handshake.
  - flush=1: next state EMPTY, head and skid cleared to 0; an offered beat is not accepted (in_ready=0).
  - stall=1 without flush: state and data held, counters aside.
- Latency: accepted beat is visible on out_data/out_valid the next cycle. Sustained throughput is 1 beat/cycle when out_ready=1.
- Order: FIFO. No duplication, no loss except on flush.
- occupancy: EMPTY=0, ONE=1, TWO=2.
- Counters: increment by 1 per qualifying cycle and hold at 2^CNT_W-1; no wrap. A cycle with flush=1 and stall=1 counts only in flush_cnt.
- Reset mid-operation: all entries dropped immediately; no partial beat emitted.
- in_data is ignored whenever in_ready=0.

Decomposition:
- Pipe_Buf_Reg_PKG gains:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_e
  - localparam for the bubble value (all zeros)
- Stage structs continue to live in Pipe_Buf_Reg_PKG and are passed as the payload.
- One sub-module: sat_counter (params CNT_W; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- Reset then single beat: in_data=0xDEADBEEF, in_valid for 1 cycle, out_ready=1 -> out_valid=1 with 0xDEADBEEF exactly 1 cycle later; occupancy returns to 0 the following cycle.
- Back-to-back stream: beats 1..8, out_ready=1 -> 8 beats out in order on consecutive cycles, no gaps.
- Skid fill, SKID=1: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0; out_ready=1 -> 0xA then 0xB out, in_ready=1 after the first pop. With SKID=0 the same stimulus yields occupancy max 1 and 0xB held upstream.
- Flush with full buffer plus concurrent push of 0xC -> next cycle occupancy=0, out_data=0, out_valid=0; 0xC never appears; flush_cnt=1.
- Stall 5 cycles holding 0x55 -> out_valid=0 and occupancy=1 throughout; 0x55 emitted after stall drops; stall_cnt=5. Stall and flush together for 1 cycle -> stall_cnt unchanged, flush_cnt +1.
- Counter saturation, CNT_W=3: stall for 10 cycles -> stall_cnt = 7 and holds. Async reset asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
